// File: rtl/program_mem_controller_if.sv
// Bundles the fetch-requester side and the external program-memory side of the
// read handshake, plus a per-channel FSM state tap for observation.
interface program_mem_controller_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
);
  // Handshake: a requester raises read_valid with a stable address and keeps
  // both until it sees read_ready==1 for exactly one cycle; data is valid in
  // that cycle and the requester may change address or drop valid at the same
  // edge. On the memory side the controller holds mem_read_valid/address
  // stable until mem_read_ready==1, then drops valid at the following edge.
  logic                 consumer_read_valid   [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0] consumer_read_address [NUM_CONSUMERS];
  logic                 consumer_read_ready   [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] consumer_read_data    [NUM_CONSUMERS];
  logic                 mem_read_valid        [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] mem_read_address      [NUM_CHANNELS];
  logic                 mem_read_ready        [NUM_CHANNELS];
  logic [DATA_BITS-1:0] mem_read_data         [NUM_CHANNELS];
  logic [1:0]           chan_state            [NUM_CHANNELS];

  modport slave (
    input  consumer_read_valid,
    input  consumer_read_address,
    output consumer_read_ready,
    output consumer_read_data,
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data,
    output chan_state
  );

  modport master (
    output consumer_read_valid,
    output consumer_read_address,
    input  consumer_read_ready,
    input  consumer_read_data,
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data,
    input  chan_state
  );
endinterface

// File: rtl/program_mem_controller.sv
// Program-memory read responder: NUM_CONSUMERS fetch requesters share
// NUM_CHANNELS memory read channels, granted round-robin, one FSM per channel.
module program_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  program_mem_controller_if.slave bus
);

  localparam int CW = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_RELAY   = 2'd2
  } state_e;

  typedef logic [CW-1:0] cidx_t;

  state_e               state_q      [NUM_CHANNELS];
  state_e               state_d      [NUM_CHANNELS];
  cidx_t                owner_q      [NUM_CHANNELS];
  cidx_t                owner_d      [NUM_CHANNELS];
  logic                 mem_valid_q  [NUM_CHANNELS];
  logic                 mem_valid_d  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] mem_addr_q   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] mem_addr_d   [NUM_CHANNELS];
  logic                 cons_ready_q [NUM_CONSUMERS];
  logic                 cons_ready_d [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] cons_data_q  [NUM_CONSUMERS];
  logic [DATA_BITS-1:0] cons_data_d  [NUM_CONSUMERS];
  cidx_t                rr_ptr_q;
  cidx_t                rr_ptr_d;

  // A consumer is unavailable while any channel owns it (WAITING or RELAY).
  logic busy [NUM_CONSUMERS];

  always_comb begin : busy_comb
    for (int c = 0; c < NUM_CONSUMERS; c++) begin
      busy[c] = 1'b0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (state_q[ch] != ST_IDLE && owner_q[ch] == cidx_t'(c)) busy[c] = 1'b1;
      end
    end
  end

  always_comb begin : next_state_comb
    logic  taken [NUM_CONSUMERS];
    logic  grant_seen;
    logic  pick_found;
    cidx_t pick_idx;
    cidx_t cand;

    grant_seen = 1'b0;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    rr_ptr_d   = rr_ptr_q;
    for (int c = 0; c < NUM_CONSUMERS; c++) begin
      taken[c]        = busy[c];
      cons_ready_d[c] = 1'b0;
      cons_data_d[c]  = cons_data_q[c];
    end
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch]     = state_q[ch];
      owner_d[ch]     = owner_q[ch];
      mem_valid_d[ch] = mem_valid_q[ch];
      mem_addr_d[ch]  = mem_addr_q[ch];
    end

    // Lower channel indices pick first; their picks are marked taken so a
    // consumer is never claimed twice in the same cycle.
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state_q[ch])
        ST_IDLE: begin
          pick_found = 1'b0;
          pick_idx   = '0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            cand = rr_ptr_q + cidx_t'(k);
            if (!pick_found && bus.consumer_read_valid[cand] && !taken[cand]) begin
              pick_found = 1'b1;
              pick_idx   = cand;
            end
          end
          if (pick_found) begin
            taken[pick_idx] = 1'b1;
            owner_d[ch]     = pick_idx;
            mem_valid_d[ch] = 1'b1;
            mem_addr_d[ch]  = bus.consumer_read_address[pick_idx];
            state_d[ch]     = ST_WAITING;
            if (!grant_seen) begin
              grant_seen = 1'b1;
              rr_ptr_d   = pick_idx + cidx_t'(1);
            end
          end
        end
        ST_WAITING: begin
          if (bus.mem_read_ready[ch]) begin
            mem_valid_d[ch]            = 1'b0;
            cons_data_d[owner_q[ch]]   = bus.mem_read_data[ch];
            cons_ready_d[owner_q[ch]]  = 1'b1;
            state_d[ch]                = ST_RELAY;
          end
        end
        ST_RELAY: state_d[ch] = ST_IDLE;
        default:  state_d[ch] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch]     <= ST_IDLE;
        owner_q[ch]     <= '0;
        mem_valid_q[ch] <= 1'b0;
        mem_addr_q[ch]  <= '0;
      end
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        cons_ready_q[c] <= 1'b0;
        cons_data_q[c]  <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch]     <= state_d[ch];
        owner_q[ch]     <= owner_d[ch];
        mem_valid_q[ch] <= mem_valid_d[ch];
        mem_addr_q[ch]  <= mem_addr_d[ch];
      end
      for (int c = 0; c < NUM_CONSUMERS; c++) begin
        cons_ready_q[c] <= cons_ready_d[c];
        cons_data_q[c]  <= cons_data_d[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CONSUMERS; c++) begin : g_cons_out
    assign bus.consumer_read_ready[c] = cons_ready_q[c];
    assign bus.consumer_read_data[c]  = cons_data_q[c];
  end

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan_out
    assign bus.mem_read_valid[ch]   = mem_valid_q[ch];
    assign bus.mem_read_address[ch] = mem_addr_q[ch];
    assign bus.chan_state[ch]       = state_q[ch];
  end

endmodule

// File: tb/tb_program_mem_controller.sv
// Bench for program_mem_controller: a 1-channel instance (dut_a) and a
// 2-channel instance (dut_b) sharing one program-memory image.
module tb_program_mem_controller;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  program_mem_controller_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) ifa ();
  program_mem_controller_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) ifb ();

  program_mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.slave));
  program_mem_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.slave));

  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;

  // Memory model: data follows the address; ready after wait_a stalled cycles,
  // force_a drives ready regardless of any request.
  int   wait_a  = 0;
  logic force_a = 1'b0;
  int   cnt_a   = 0;

  always_comb begin
    ifa.mem_read_data[0]  = mem[ifa.mem_read_address[0]];
    ifa.mem_read_ready[0] = (ifa.mem_read_valid[0] && cnt_a >= wait_a) || force_a;
    for (int ch = 0; ch < 2; ch++) begin
      ifb.mem_read_data[ch]  = mem[ifb.mem_read_address[ch]];
      ifb.mem_read_ready[ch] = ifb.mem_read_valid[ch];
    end
  end

  always @(posedge clk)
    cnt_a <= (ifa.mem_read_valid[0] && !ifa.mem_read_ready[0]) ? cnt_a + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] cready_a();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = ifa.consumer_read_ready[c];
    return r;
  endfunction

  function automatic logic [3:0] cready_b();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = ifb.consumer_read_ready[c];
    return r;
  endfunction

  task automatic set_a(input int c, input logic v, input logic [7:0] a);
    ifa.consumer_read_valid[c]   = v;
    ifa.consumer_read_address[c] = a;
  endtask

  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [7:0]  addr;
    logic        e_mv;
    logic [7:0]  e_ma;
    logic        e_cr;
    logic [15:0] e_cd;
  } vec_t;

  vec_t vecs [9];

  // Scoreboard for the randomized run: {consumer, data} and due sample index.
  logic [17:0] exp_q [$];
  int          due_q [$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    int          served_n, last_t, grants, t_mv, n;
    logic        prev_mv, seen;
    logic [7:0]  addr_cur;
    logic [3:0]  exp_r;
    int          rr, next_free, served, cc;
    logic        m_valid [4];
    logic [7:0]  m_addr  [4];
    logic [15:0] last_data [4];
    logic [17:0] e;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[5] = 16'hABCD;
    for (int c = 0; c < 4; c++) begin
      set_a(c, 1'b0, 8'h00);
      ifb.consumer_read_valid[c]   = 1'b0;
      ifb.consumer_read_address[c] = 8'h00;
    end

    // Reset, single request, zero-wait latency, hold of data, next request.
    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 8'h05, 1'b1, 8'h05, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 8'h05, 1'b0, 8'h05, 1'b1, 16'hABCD};
    vecs[4] = '{1'b1, 1'b1, 8'h06, 1'b0, 8'h05, 1'b0, 16'hABCD};
    vecs[5] = '{1'b1, 1'b1, 8'h06, 1'b1, 8'h06, 1'b0, 16'hABCD};
    vecs[6] = '{1'b1, 1'b0, 8'h06, 1'b0, 8'h06, 1'b1, mem[6]};
    vecs[7] = '{1'b1, 1'b0, 8'h06, 1'b0, 8'h06, 1'b0, mem[6]};
    vecs[8] = '{1'b1, 1'b0, 8'h06, 1'b0, 8'h06, 1'b0, mem[6]};
    for (int i = 0; i < 9; i++) begin
      rst_a = vecs[i].rst_n;
      set_a(0, vecs[i].vld, vecs[i].addr);
      step();
      chk($sformatf("vec%0d mem_valid", i), 32'(ifa.mem_read_valid[0]), 32'(vecs[i].e_mv));
      chk($sformatf("vec%0d mem_addr", i), 32'(ifa.mem_read_address[0]), 32'(vecs[i].e_ma));
      chk($sformatf("vec%0d ready", i), 32'(cready_a()), {31'd0, vecs[i].e_cr});
      chk($sformatf("vec%0d data", i), 32'(ifa.consumer_read_data[0]), 32'(vecs[i].e_cd));
    end

    // Fetcher-style burst from consumer 1.
    addr_cur = 8'h10; served_n = 0; last_t = -1; grants = 0; prev_mv = 1'b0;
    set_a(1, 1'b1, addr_cur);
    for (int t = 0; t < 60 && served_n < 4; t++) begin
      step();
      if (ifa.mem_read_valid[0] && !prev_mv) grants++;
      prev_mv = ifa.mem_read_valid[0];
      if (ifa.consumer_read_ready[1]) begin
        chk("burst data", 32'(ifa.consumer_read_data[1]), 32'(mem[addr_cur]));
        if (last_t >= 0) chk("burst spacing", t - last_t, 3);
        last_t = t;
        served_n++;
        addr_cur++;
        if (served_n == 4) set_a(1, 1'b0, addr_cur);
        else set_a(1, 1'b1, addr_cur);
      end
    end
    for (int t = 0; t < 5; t++) begin
      step();
      if (ifa.mem_read_valid[0] && !prev_mv) grants++;
      prev_mv = ifa.mem_read_valid[0];
    end
    chk("burst completions", served_n, 4);
    chk("burst requests", grants, 4);

    // Round-robin fairness with all four consumers requesting continuously.
    rst_a = 1'b0; step(); rst_a = 1'b1;
    for (int c = 0; c < 4; c++) set_a(c, 1'b1, 8'(8'h20 + c));
    n = 0;
    for (int t = 0; t < 100 && n < 12; t++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        if (ifa.consumer_read_ready[c]) begin
          chk("rr order", c, n % 4);
          chk("rr data", 32'(ifa.consumer_read_data[c]), 32'(mem[8'h20 + c]));
          n++;
        end
      end
    end
    chk("rr grants", n, 12);
    for (int c = 0; c < 4; c++) set_a(c, 1'b0, 8'h00);
    for (int t = 0; t < 6; t++) step();

    // Two channels serve two consumers in parallel.
    rst_b = 1'b0; step(); rst_b = 1'b1;
    ifb.consumer_read_valid[0] = 1'b1; ifb.consumer_read_address[0] = 8'h40;
    ifb.consumer_read_valid[2] = 1'b1; ifb.consumer_read_address[2] = 8'h42;
    step();
    chk("mc ch0 valid", 32'(ifb.mem_read_valid[0]), 1);
    chk("mc ch0 addr", 32'(ifb.mem_read_address[0]), 32'h40);
    chk("mc ch1 valid", 32'(ifb.mem_read_valid[1]), 1);
    chk("mc ch1 addr", 32'(ifb.mem_read_address[1]), 32'h42);
    step();
    chk("mc ready", 32'(cready_b()), 32'b0101);
    chk("mc data0", 32'(ifb.consumer_read_data[0]), 32'(mem[8'h40]));
    chk("mc data2", 32'(ifb.consumer_read_data[2]), 32'(mem[8'h42]));
    ifb.consumer_read_valid[0] = 1'b0;
    ifb.consumer_read_valid[2] = 1'b0;
    step();
    chk("mc ready after", 32'(cready_b()), 0);
    chk("mc valid after", 32'({ifb.mem_read_valid[1], ifb.mem_read_valid[0]}), 0);
    step();
    chk("mc states idle", 32'({ifb.chan_state[1], ifb.chan_state[0]}), 0);

    // Memory wait states: ready after 5 stalled cycles.
    wait_a = 5;
    set_a(3, 1'b1, 8'h33);
    for (int t = 0; t < 9; t++) begin
      step();
      chk($sformatf("wait mv t%0d", t), 32'(ifa.mem_read_valid[0]), (t <= 5) ? 1 : 0);
      chk($sformatf("wait ready t%0d", t), 32'(cready_a()), (t == 6) ? 32'b1000 : 0);
      if (t <= 5) chk("wait addr", 32'(ifa.mem_read_address[0]), 32'h33);
      if (t == 6) begin
        chk("wait data", 32'(ifa.consumer_read_data[3]), 32'(mem[8'h33]));
        set_a(3, 1'b0, 8'h33);
      end
    end
    wait_a = 0;

    // Reset while WAITING; ready arriving afterwards is ignored.
    wait_a = 1000;
    set_a(2, 1'b1, 8'h44);
    step(); step();
    chk("rst mid waiting", 32'(ifa.mem_read_valid[0]), 1);
    rst_a = 1'b0;
    set_a(2, 1'b0, 8'h44);
    step();
    chk("rst mv", 32'(ifa.mem_read_valid[0]), 0);
    chk("rst maddr", 32'(ifa.mem_read_address[0]), 0);
    chk("rst data3", 32'(ifa.consumer_read_data[3]), 0);
    rst_a = 1'b1;
    force_a = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      chk("post rst ready", 32'(cready_a()), 0);
      chk("post rst mv", 32'(ifa.mem_read_valid[0]), 0);
      chk("post rst state", 32'(ifa.chan_state[0]), 0);
    end
    force_a = 1'b0;
    wait_a = 0;
    set_a(1, 1'b1, 8'h51);
    set_a(3, 1'b1, 8'h53);
    step();
    chk("post rst grant addr", 32'(ifa.mem_read_address[0]), 32'h51);
    step();
    chk("post rst ready1", 32'(cready_a()), 32'b0010);
    chk("post rst data1", 32'(ifa.consumer_read_data[1]), 32'(mem[8'h51]));
    set_a(1, 1'b0, 8'h51);
    step(); step();
    chk("post rst grant3", 32'(ifa.mem_read_address[0]), 32'h53);
    step();
    chk("post rst ready3", 32'(cready_a()), 32'b1000);
    set_a(3, 1'b0, 8'h53);
    step();

    // Randomized requests against a transaction-level model: one channel
    // finishes a zero-wait fetch in 3 cycles; grants rotate round-robin.
    rst_a = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_a(c, 1'b0, 8'h00);
      m_valid[c] = 1'b0; m_addr[c] = 8'h00; last_data[c] = 16'h0000;
    end
    step();
    rst_a = 1'b1;
    rr = 0; next_free = 0;
    for (int k = 0; k < 300; k++) begin
      if (k >= next_free) begin
        seen = 1'b0; cc = 0;
        for (int j = 0; j < 4; j++) begin
          if (!seen && m_valid[(rr + j) % 4]) begin
            seen = 1'b1;
            cc = (rr + j) % 4;
          end
        end
        if (seen) begin
          exp_q.push_back({2'(cc), mem[m_addr[cc]]});
          due_q.push_back(k + 1);
          rr = (cc + 1) % 4;
          next_free = k + 3;
        end
      end
      step();
      exp_r = 4'b0000;
      served = -1;
      if (due_q.size() > 0 && due_q[0] == k) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        served = int'(e[17:16]);
        exp_r[served] = 1'b1;
        last_data[served] = e[15:0];
      end
      chk("rand ready", 32'(cready_a()), 32'(exp_r));
      for (int c = 0; c < 4; c++)
        chk("rand data", 32'(ifa.consumer_read_data[c]), 32'(last_data[c]));
      for (int c = 0; c < 4; c++) begin
        if (c == served) begin
          m_valid[c] = ($urandom_range(0, 3) != 0);
          m_addr[c]  = 8'($urandom_range(0, 255));
        end else if (!m_valid[c] && $urandom_range(0, 3) == 0) begin
          m_valid[c] = 1'b1;
          m_addr[c]  = 8'($urandom_range(0, 255));
        end
        set_a(c, m_valid[c], m_addr[c]);
      end
    end
    chk("rand pending", due_q.size() <= 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_mem_controller.md
Name: program_mem_controller

Overview:
- Responder side of the program-memory read handshake.
- Serves NUM_CONSUMERS fetch requesters (one per core), each using the valid/address to ready/data protocol, over NUM_CHANNELS read channels to external program memory.
- Each channel runs its own FSM. Consumers are granted round-robin. Each response is returned as a one-cycle ready pulse, so a requester can hold valid high and present its next address immediately.

Parameters:
- ADDR_BITS, 8, program memory address width
- DATA_BITS, 16, instruction word width
- NUM_CONSUMERS, 4, number of requesters; power of two, at least 2
- NUM_CHANNELS, 1, number of external memory read channels; at least 1 and at most NUM_CONSUMERS

Ports:
- clk  input  1  clock; all logic on the rising edge
- reset  input  1  synchronous, active-low reset; 0 resets the block at the next edge
- consumer_read_valid  input  1 x NUM_CONSUMERS (unpacked)  request pending
- consumer_read_address  input  ADDR_BITS x NUM_CONSUMERS (unpacked)  request address
- consumer_read_ready  output  1 x NUM_CONSUMERS (unpacked)  one-cycle response strobe
- consumer_read_data  output  DATA_BITS x NUM_CONSUMERS (unpacked)  response word
- mem_read_valid  output  1 x NUM_CHANNELS (unpacked)  channel request to memory
- mem_read_address  output  ADDR_BITS x NUM_CHANNELS (unpacked)  channel address
- mem_read_ready  input  1 x NUM_CHANNELS (unpacked)  memory data valid
- mem_read_data  input  DATA_BITS x NUM_CHANNELS (unpacked)  memory data

Behaviour:
- Reset (reset==0 at an edge):
  - All outputs go to 0.
  - Every channel returns to IDLE.
  - All consumer claims are cleared and the round-robin pointer is set to 0.
  - An in-flight memory response is discarded and never forwarded; memory must tolerate valid dropping mid-request.
- Per-channel FSM states: IDLE, WAITING, RELAY.
- IDLE:
  - Scan consumers starting at rr_ptr, wrapping modulo NUM_CONSUMERS.
  - Pick the first consumer that has valid==1, is not claimed by any channel, and is not in RELAY on any channel.
  - On a pick: claim the consumer, register mem_read_valid<=1 and mem_read_address<=that consumer's address, go to WAITING.
  - Channels are evaluated in ascending index order within one cycle. A consumer picked by a lower-index channel in a cycle is unavailable to higher-index channels in the same cycle.
- WAITING:
  - Hold mem_read_valid and mem_read_address stable until mem_read_ready==1.
  - On ready: mem_read_valid<=0, consumer_read_data<=mem_read_data, consumer_read_ready<=1, go to RELAY.
- RELAY:
  - Lasts exactly one cycle, the cycle in which consumer_read_ready is high.
  - At the next edge: consumer_read_ready<=0, release the claim, go to IDLE.
- Consumer contract: the consumer samples data on the edge where it sees ready==1 and may change its address or drop valid at that same edge. Valid still high in the following cycle is treated as a new request.
- Round-robin pointer: rr_ptr <= (highest-priority consumer granted this cycle, i.e. the first grant in scan order) + 1, modulo NUM_CONSUMERS. Unchanged if no grant.
- Latency with an idle channel and zero-wait memory (mem_read_ready high in the first cycle mem_read_valid is high):
  - Request seen in cycle 0, mem_read_valid high in cycle 1, consumer_read_ready high in cycle 2.
  - Back-to-back requests from one consumer on one channel therefore complete every 3 cycles.
- consumer_read_data holds its value after the ready pulse until the next response to that consumer.
- At most one consumer_read_ready per consumer per cycle. Different consumers may be strobed in the same cycle by different channels.
- A consumer that drops valid while claimed: the memory transaction completes and the ready pulse is still issued (the consumer ignores it).
- mem_read_ready seen while a channel is in IDLE or RELAY is ignored.

Test Plan:
- Reset and single request:
  - Stimulus: reset=0 for 2 cycles, then release. Consumer 0 requests addr 0x05; memory returns 0xABCD with zero wait.
  - Required: all outputs 0 during reset; mem_read_valid[0] high in cycle 1 with addr 0x05; consumer_read_ready[0] high in cycle 2 only, with data 0xABCD.
- Fetcher-style burst:
  - Stimulus: consumer 1 holds valid high and steps its address 0x10, 0x11, 0x12, 0x13, advancing on each ready pulse.
  - Required: four ready pulses exactly 3 cycles apart, data matching memory contents; no duplicate request for any address.
- Round-robin fairness:
  - Stimulus: NUM_CHANNELS=1, all 4 consumers hold valid high continuously.
  - Required: grants go 0,1,2,3,0,…; no consumer gets a second grant before all others have been served once.
- Multi-channel:
  - Stimulus: NUM_CHANNELS=2; consumers 0 and 2 request in the same cycle.
  - Required: channel 0 serves consumer 0 and channel 1 serves consumer 2; both ready pulses occur in the same cycle; no consumer is double-claimed.
- Memory wait states:
  - Stimulus: mem_read_ready is delayed 5 cycles.
  - Required: mem_read_address is stable throughout the wait; mem_read_valid drops on the edge after ready; the consumer ready pulse is one cycle wide.
- Reset mid-operation:
  - Stimulus: assert reset while a channel is in WAITING, then release; memory asserts ready afterwards.
  - Required: no consumer_read_ready pulse; channel is IDLE; the next request is served normally with rr_ptr starting at 0.
